// File: rtl/seg_rw_arbiter.sv
// Round-robin arbiter sharing one read/write segment operator between NREQ
// requesters. Issued accesses are tagged in an in-order FIFO so returned read
// data can be routed back to its owner; end-of-stream is collected from every
// requester, forwarded to the segment, then broadcast back to all requesters.
module seg_rw_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ*AW-1:0]   req_addr_d,
    input  logic [NREQ-1:0]      req_addr_e,
    input  logic [NREQ-1:0]      req_addr_v,
    output logic [NREQ-1:0]      req_addr_b,
    input  logic [NREQ*DW-1:0]   req_dataW_d,
    input  logic [NREQ-1:0]      req_dataW_e,
    input  logic [NREQ-1:0]      req_dataW_v,
    output logic [NREQ-1:0]      req_dataW_b,
    input  logic [NREQ-1:0]      req_write_d,
    input  logic [NREQ-1:0]      req_write_e,
    input  logic [NREQ-1:0]      req_write_v,
    output logic [NREQ-1:0]      req_write_b,
    output logic [NREQ*DW-1:0]   req_dataR_d,
    output logic [NREQ-1:0]      req_dataR_e,
    output logic [NREQ-1:0]      req_dataR_v,
    input  logic [NREQ-1:0]      req_dataR_b,
    output logic [AW-1:0]        seg_addr_d,
    output logic                 seg_addr_e,
    output logic                 seg_addr_v,
    input  logic                 seg_addr_b,
    output logic [DW-1:0]        seg_dataW_d,
    output logic                 seg_dataW_e,
    output logic                 seg_dataW_v,
    input  logic                 seg_dataW_b,
    output logic                 seg_write_d,
    output logic                 seg_write_e,
    output logic                 seg_write_v,
    input  logic                 seg_write_b,
    input  logic [DW-1:0]        seg_dataR_d,
    input  logic                 seg_dataR_e,
    input  logic                 seg_dataR_v,
    output logic                 seg_dataR_b,
    output logic                 err
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TAG_DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_SEOS = 3'd2;
    localparam logic [2:0] ST_REOS = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    logic [2:0]       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic             lock_v_r;
    logic [IDX_W-1:0] lock_g_r;
    logic [NREQ-1:0]  done_r;
    logic [2:0]       seos_acc_r;
    logic [NREQ-1:0]  reos_acc_r;
    logic             err_r;
    logic [IDX_W-1:0] tag_owner_r [TAG_DEPTH];
    logic [TAG_DEPTH-1:0] tag_wr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [NREQ-1:0]  elig_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             cand_found_s;
    logic [IDX_W-1:0] gnt_s;
    logic             run_s;
    logic             full_s;
    logic             empty_s;
    logic             eos_s;
    logic             issue_s;
    logic             stall_s;
    logic             push_s;
    logic             pop_s;
    logic             spur_s;
    logic [2:0]       seos_take_s;
    logic [NREQ-1:0]  reos_take_s;
    logic [IDX_W-1:0] head_owner_s;
    logic             head_wr_s;
    logic             resp_en_s;

    assign run_s        = (state_r == ST_RUN);
    assign full_s       = (count_r == FULL_CNT);
    assign empty_s      = (count_r == '0);
    assign elig_s       = req_addr_v & req_dataW_v & req_write_v & ~done_r;
    assign gnt_s        = lock_v_r ? lock_g_r : cand_s;
    assign stall_s      = seg_addr_b | seg_dataW_b | seg_write_b;
    // Streams of a requester are aligned, so any eos flag on its triple ends it.
    assign eos_s        = run_s && !lock_v_r && cand_found_s &&
                          (req_addr_e[cand_s] | req_dataW_e[cand_s] | req_write_e[cand_s]);
    // Fullness uses the registered count: a same-cycle pop cannot unblock issue.
    assign issue_s      = run_s && (lock_v_r || (cand_found_s && !eos_s && !full_s));
    assign push_s       = issue_s && !stall_s;
    assign head_owner_s = tag_owner_r[rd_ptr_r];
    assign head_wr_s    = tag_wr_r[rd_ptr_r];
    assign resp_en_s    = (state_r == ST_RUN) || (state_r == ST_SEOS) || (state_r == ST_REOS);
    assign seos_take_s  = {seg_write_v & ~seg_write_b, seg_dataW_v & ~seg_dataW_b, seg_addr_v & ~seg_addr_b};
    assign reos_take_s  = req_dataR_v & req_dataR_e & ~req_dataR_b;
    assign err          = err_r;

    // Round-robin search: first eligible requester after the pointer.
    always_comb begin
        cand_found_s = 1'b0;
        cand_s       = '0;
        idx_s        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IDX_W'((int'(ptr_r) + k) % NREQ);
            if (!cand_found_s && elig_s[idx_s]) begin
                cand_found_s = 1'b1;
                cand_s       = idx_s;
            end else begin
                cand_s = cand_s;
            end
        end
    end

    // Access path and segment-side eos: combinational forwarding of the granted requester.
    always_comb begin
        req_addr_b  = '1;
        req_dataW_b = '1;
        req_write_b = '1;
        seg_addr_d  = '0;
        seg_dataW_d = '0;
        seg_write_d = 1'b0;
        seg_addr_v  = 1'b0;
        seg_dataW_v = 1'b0;
        seg_write_v = 1'b0;
        seg_addr_e  = 1'b0;
        seg_dataW_e = 1'b0;
        seg_write_e = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (issue_s) begin
                    seg_addr_d          = req_addr_d[int'(gnt_s)*AW +: AW];
                    seg_dataW_d         = req_dataW_d[int'(gnt_s)*DW +: DW];
                    seg_write_d         = req_write_d[gnt_s];
                    seg_addr_v          = 1'b1;
                    seg_dataW_v         = 1'b1;
                    seg_write_v         = 1'b1;
                    req_addr_b[gnt_s]   = stall_s;
                    req_dataW_b[gnt_s]  = stall_s;
                    req_write_b[gnt_s]  = stall_s;
                end else if (eos_s) begin
                    req_addr_b[cand_s]  = 1'b0;
                    req_dataW_b[cand_s] = 1'b0;
                    req_write_b[cand_s] = 1'b0;
                end else begin
                    seg_addr_v = 1'b0;
                end
            end
            ST_SEOS: begin
                seg_addr_v  = ~seos_acc_r[0];
                seg_addr_e  = ~seos_acc_r[0];
                seg_dataW_v = ~seos_acc_r[1];
                seg_dataW_e = ~seos_acc_r[1];
                seg_write_v = ~seos_acc_r[2];
                seg_write_e = ~seos_acc_r[2];
            end
            default: begin
                seg_addr_v = 1'b0;
            end
        endcase
    end

    // Response routing: head-of-FIFO owner receives reads; writes and strays are dropped.
    always_comb begin
        seg_dataR_b = 1'b1;
        req_dataR_d = '0;
        req_dataR_v = '0;
        req_dataR_e = '0;
        pop_s       = 1'b0;
        spur_s      = 1'b0;
        if (resp_en_s) begin
            if (seg_dataR_e) begin
                seg_dataR_b = 1'b0;
            end else if (empty_s) begin
                seg_dataR_b = 1'b0;
                spur_s      = seg_dataR_v;
            end else if (head_wr_s) begin
                seg_dataR_b = 1'b0;
                pop_s       = seg_dataR_v;
            end else begin
                req_dataR_v[head_owner_s]                 = seg_dataR_v;
                req_dataR_d[int'(head_owner_s)*DW +: DW] = seg_dataR_d;
                seg_dataR_b = req_dataR_b[head_owner_s];
                pop_s       = seg_dataR_v & ~req_dataR_b[head_owner_s];
            end
        end else begin
            seg_dataR_b = 1'b1;
        end
        if (state_r == ST_REOS) begin
            req_dataR_v = ~reos_acc_r;
            req_dataR_e = ~reos_acc_r;
        end else begin
            req_dataR_e = '0;
        end
    end

    // Sequencing FSM with per-stream eos acceptance tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            seos_acc_r <= 3'b000;
            reos_acc_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_RUN;
                ST_RUN: begin
                    if ((&done_r) && empty_s) begin
                        state_r <= ST_SEOS;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_SEOS: begin
                    seos_acc_r <= seos_acc_r | seos_take_s;
                    if (&(seos_acc_r | seos_take_s)) begin
                        state_r <= ST_REOS;
                    end else begin
                        state_r <= ST_SEOS;
                    end
                end
                ST_REOS: begin
                    reos_acc_r <= reos_acc_r | reos_take_s;
                    if (&(reos_acc_r | reos_take_s)) begin
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_REOS;
                    end
                end
                ST_FIN:  state_r <= ST_FIN;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Arbitration state: pointer, grant lock across stalls, per-requester done flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r    <= IDX_W'(NREQ - 1);
            lock_v_r <= 1'b0;
            lock_g_r <= '0;
            done_r   <= '0;
        end else begin
            lock_v_r <= issue_s & stall_s;
            lock_g_r <= gnt_s;
            if (push_s) begin
                ptr_r <= gnt_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (eos_s) begin
                done_r[cand_s] <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    // In-order tag FIFO of {owner, write} for every issued access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            tag_wr_r <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_owner_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                tag_owner_r[wr_ptr_r] <= gnt_s;
                tag_wr_r[wr_ptr_r]    <= seg_write_d;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        end
    end

    // Sticky error: a data token arrived with nothing outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | spur_s;
        end
    end
endmodule

// File: tb/tb_seg_rw_arbiter.sv
// Directed bench for seg_rw_arbiter with a response scoreboard: each issued
// access is queued with its expected read data, and every returned token is
// checked against the queue head.
module tb_seg_rw_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ*AW-1:0]   req_addr_d;
    logic [NREQ-1:0]      req_addr_e, req_addr_v, req_addr_b;
    logic [NREQ*DW-1:0]   req_dataW_d;
    logic [NREQ-1:0]      req_dataW_e, req_dataW_v, req_dataW_b;
    logic [NREQ-1:0]      req_write_d, req_write_e, req_write_v, req_write_b;
    logic [NREQ*DW-1:0]   req_dataR_d;
    logic [NREQ-1:0]      req_dataR_e, req_dataR_v, req_dataR_b;
    logic [AW-1:0]        seg_addr_d;
    logic                 seg_addr_e, seg_addr_v, seg_addr_b;
    logic [DW-1:0]        seg_dataW_d;
    logic                 seg_dataW_e, seg_dataW_v, seg_dataW_b;
    logic                 seg_write_d, seg_write_e, seg_write_v, seg_write_b;
    logic [DW-1:0]        seg_dataR_d;
    logic                 seg_dataR_e, seg_dataR_v, seg_dataR_b;
    logic                 err;

    seg_rw_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAG_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .req_addr_d(req_addr_d), .req_addr_e(req_addr_e), .req_addr_v(req_addr_v), .req_addr_b(req_addr_b),
        .req_dataW_d(req_dataW_d), .req_dataW_e(req_dataW_e), .req_dataW_v(req_dataW_v), .req_dataW_b(req_dataW_b),
        .req_write_d(req_write_d), .req_write_e(req_write_e), .req_write_v(req_write_v), .req_write_b(req_write_b),
        .req_dataR_d(req_dataR_d), .req_dataR_e(req_dataR_e), .req_dataR_v(req_dataR_v), .req_dataR_b(req_dataR_b),
        .seg_addr_d(seg_addr_d), .seg_addr_e(seg_addr_e), .seg_addr_v(seg_addr_v), .seg_addr_b(seg_addr_b),
        .seg_dataW_d(seg_dataW_d), .seg_dataW_e(seg_dataW_e), .seg_dataW_v(seg_dataW_v), .seg_dataW_b(seg_dataW_b),
        .seg_write_d(seg_write_d), .seg_write_e(seg_write_e), .seg_write_v(seg_write_v), .seg_write_b(seg_write_b),
        .seg_dataR_d(seg_dataR_d), .seg_dataR_e(seg_dataR_e), .seg_dataR_v(seg_dataR_v), .seg_dataR_b(seg_dataR_b),
        .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic            wr;
        int              owner;
        logic [DW-1:0]   rdata;
    } acc_t;

    acc_t pend_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [NREQ-1:0] nb(input int g);
        logic [NREQ-1:0] m;
        m    = '1;
        m[g] = 1'b0;
        return m;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int g);
        logic [NREQ-1:0] m;
        m    = '0;
        m[g] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        seg_dataR_v = 1'b0;
        seg_dataR_e = 1'b0;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [AW-1:0] a,
                             input logic [DW-1:0] w, input logic wr, input logic e);
        req_addr_v[i] = v;  req_dataW_v[i] = v;  req_write_v[i] = v;
        req_addr_e[i] = e;  req_dataW_e[i] = e;  req_write_e[i] = e;
        req_addr_d[i*AW +: AW]  = a;
        req_dataW_d[i*DW +: DW] = w;
        req_write_d[i]          = wr;
    endtask

    // Expect requester g to be forwarded unstalled; queue its expected response.
    task automatic chk_issue(input string tag, input int g, input logic [AW-1:0] a,
                             input logic [DW-1:0] w, input logic wr);
        acc_t t;
        chk({tag, "_segv"}, {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd7);
        chk({tag, "_addr"}, {48'd0, seg_addr_d}, {48'd0, a});
        chk({tag, "_dataW"}, {32'd0, seg_dataW_d}, {32'd0, w});
        chk({tag, "_wr"}, {63'd0, seg_write_d}, {63'd0, wr});
        chk({tag, "_reqb"}, {62'd0, req_addr_b}, {62'd0, nb(g)});
        t.wr    = wr;
        t.owner = g;
        t.rdata = wr ? 32'hFFFF_0000 : rdata_of(a);
        pend_q.push_back(t);
    endtask

    task automatic start_resp();
        if (pend_q.size() > 0) begin
            seg_dataR_v = 1'b1;
            seg_dataR_d = pend_q[0].rdata;
        end else begin
            seg_dataR_v = 1'b0;
        end
    endtask

    task automatic chk_resp(input string tag);
        acc_t t;
        t = pend_q[0];
        if (t.wr) begin
            chk({tag, "_wr_v"}, {62'd0, req_dataR_v}, 64'd0);
            chk({tag, "_wr_b"}, {63'd0, seg_dataR_b}, 64'd0);
            void'(pend_q.pop_front());
        end else begin
            chk({tag, "_rd_v"}, {62'd0, req_dataR_v}, {62'd0, oh(t.owner)});
            chk({tag, "_rd_d"}, {32'd0, req_dataR_d[t.owner*DW +: DW]}, {32'd0, t.rdata});
            chk({tag, "_rd_b"}, {63'd0, seg_dataR_b}, {63'd0, req_dataR_b[t.owner]});
            if (!req_dataR_b[t.owner]) begin
                void'(pend_q.pop_front());
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 8 && pend_q.size() > 0; n++) begin
            start_resp();
            #1;
            chk_resp(tag);
            tick();
        end
        chk({tag, "_empty"}, 64'(pend_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        req_addr_d = '0;  req_addr_e = '0;  req_addr_v = '0;
        req_dataW_d = '0; req_dataW_e = '0; req_dataW_v = '0;
        req_write_d = '0; req_write_e = '0; req_write_v = '0;
        req_dataR_b = '0;
        seg_addr_b = 1'b0; seg_dataW_b = 1'b0; seg_write_b = 1'b0;
        seg_dataR_d = '0;  seg_dataR_e = 1'b0; seg_dataR_v = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_segv", {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd0);
        chk("rst_sege", {61'd0, seg_addr_e, seg_dataW_e, seg_write_e}, 64'd0);
        chk("rst_reqb", {58'd0, req_addr_b, req_dataW_b, req_write_b}, 64'h3F);
        chk("rst_rv", {60'd0, req_dataR_v, req_dataR_e}, 64'd0);
        chk("rst_srb", {63'd0, seg_dataR_b}, 64'd1);
        chk("rst_err", {63'd0, err}, 64'd0);
        reset = 1'b1;

        // IDLE: no grant even with an eligible requester
        drive_req(0, 1'b1, 16'h0010, 32'd0, 1'b0, 1'b0);
        #1;
        chk("idle_reqb", {62'd0, req_addr_b}, 64'h3);
        chk("idle_segv", {63'd0, seg_addr_v}, 64'd0);
        tick();

        // Test 1: two reads from req0, latency 1
        drive_req(0, 1'b1, 16'h0010, 32'd0, 1'b0, 1'b0);
        #1;
        chk_issue("t1a", 0, 16'h0010, 32'd0, 1'b0);
        tick();
        drive_req(0, 1'b1, 16'h0011, 32'd0, 1'b0, 1'b0);
        start_resp();
        #1;
        chk_resp("t1r0");
        chk_issue("t1b", 0, 16'h0011, 32'd0, 1'b0);
        tick();
        drive_req(0, 1'b0, 16'h0000, 32'd0, 1'b0, 1'b0);
        start_resp();
        #1;
        chk_resp("t1r1");
        chk("t1_idleb", {62'd0, req_addr_b}, 64'h3);
        tick();

        // Test 2: both eligible every cycle; grants alternate starting with req1
        for (int k = 0; k < 5; k++) begin
            drive_req(0, 1'b1, 16'h0100 + 16'(2*k), 32'h1000 + 32'(k), 1'b0, 1'b0);
            drive_req(1, 1'b1, 16'h0101 + 16'(2*k), 32'h2000 + 32'(k), 1'b0, 1'b0);
            start_resp();
            #1;
            if (seg_dataR_v) chk_resp("t2r");
            if (k % 2 == 0) chk_issue("t2g1", 1, 16'h0101 + 16'(2*k), 32'h2000 + 32'(k), 1'b0);
            else            chk_issue("t2g0", 0, 16'h0100 + 16'(2*k), 32'h1000 + 32'(k), 1'b0);
            tick();
        end
        drive_req(0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        drive_req(1, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        drain("t2d");

        // Test 3: stall while req1 granted; req0 joins but is never granted
        drive_req(1, 1'b1, 16'h0300, 32'h33, 1'b0, 1'b0);
        seg_addr_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) drive_req(0, 1'b1, 16'h0200, 32'h22, 1'b0, 1'b0);
            #1;
            chk("t3_segv", {63'd0, seg_addr_v}, 64'd1);
            chk("t3_addr", {48'd0, seg_addr_d}, 64'h0300);
            chk("t3_reqb", {62'd0, req_addr_b}, 64'h3);
            chk("t3_wb", {62'd0, req_dataW_b}, 64'h3);
            tick();
        end
        seg_addr_b = 1'b0;
        #1;
        chk_issue("t3g1", 1, 16'h0300, 32'h33, 1'b0);
        tick();
        drive_req(1, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        #1;
        chk_issue("t3g0", 0, 16'h0200, 32'h22, 1'b0);
        tick();
        drive_req(0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        drain("t3d");

        // Test 4: fill the tag FIFO; 5th access blocked until a pop has registered
        for (int k = 0; k < 4; k++) begin
            drive_req(0, 1'b1, 16'h0400 + 16'(k), 32'd0, 1'b0, 1'b0);
            #1;
            chk_issue("t4i", 0, 16'h0400 + 16'(k), 32'd0, 1'b0);
            tick();
        end
        drive_req(0, 1'b1, 16'h0404, 32'd0, 1'b0, 1'b0);
        #1;
        chk("t4_full_b", {62'd0, req_addr_b}, 64'h3);
        chk("t4_full_v", {63'd0, seg_addr_v}, 64'd0);
        tick();
        start_resp();
        #1;
        chk("t4_popblk_b", {62'd0, req_addr_b}, 64'h3);
        chk_resp("t4r0");
        tick();
        start_resp();
        #1;
        chk_resp("t4r1");
        chk_issue("t4i5", 0, 16'h0404, 32'd0, 1'b0);
        tick();
        drive_req(0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        drain("t4d");

        // Test 5: write then read from req0; write response discarded
        drive_req(0, 1'b1, 16'h0500, 32'h0000_00A5, 1'b1, 1'b0);
        #1;
        chk_issue("t5w", 0, 16'h0500, 32'h0000_00A5, 1'b1);
        tick();
        drive_req(0, 1'b1, 16'h0501, 32'd0, 1'b0, 1'b0);
        start_resp();
        #1;
        chk_resp("t5rw");
        chk_issue("t5r", 0, 16'h0501, 32'd0, 1'b0);
        tick();
        drive_req(0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        req_dataR_b = 2'b01;
        start_resp();
        #1;
        chk_resp("t5bp");
        tick();
        req_dataR_b = 2'b00;
        drain("t5d");
        chk("t5_err", {63'd0, err}, 64'd0);

        // Test 6: eos from both requesters, spurious dataR, eos sequencing
        drive_req(0, 1'b1, 16'h0, 32'd0, 1'b0, 1'b1);
        #1;
        chk("t6_eos0_b", {58'd0, req_addr_b, req_dataW_b, req_write_b}, 64'h2A);
        chk("t6_eos0_v", {63'd0, seg_addr_v}, 64'd0);
        tick();
        drive_req(0, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        drive_req(1, 1'b1, 16'h0, 32'd0, 1'b0, 1'b1);
        #1;
        chk("t6_eos1_b", {58'd0, req_addr_b, req_dataW_b, req_write_b}, 64'h15);
        tick();
        drive_req(1, 1'b0, 16'h0, 32'd0, 1'b0, 1'b0);
        seg_dataR_v = 1'b1;
        seg_dataR_d = 32'h1234;
        #1;
        chk("t6_spur_b", {63'd0, seg_dataR_b}, 64'd0);
        chk("t6_spur_rv", {62'd0, req_dataR_v}, 64'd0);
        chk("t6_run_e", {63'd0, seg_addr_e}, 64'd0);
        tick();
        seg_addr_b = 1'b0; seg_dataW_b = 1'b1; seg_write_b = 1'b1;
        #1;
        chk("t6_err", {63'd0, err}, 64'd1);
        chk("t6_seos_v", {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd7);
        chk("t6_seos_e", {61'd0, seg_addr_e, seg_dataW_e, seg_write_e}, 64'd7);
        tick();
        seg_dataW_b = 1'b0;
        #1;
        chk("t6_seos_v2", {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd3);
        chk("t6_seos_e2", {61'd0, seg_addr_e, seg_dataW_e, seg_write_e}, 64'd3);
        tick();
        seg_write_b = 1'b0;
        #1;
        chk("t6_seos_v3", {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd1);
        tick();
        req_dataR_b = 2'b10;
        #1;
        chk("t6_reos_v", {62'd0, req_dataR_v}, 64'h3);
        chk("t6_reos_e", {62'd0, req_dataR_e}, 64'h3);
        chk("t6_reos_segv", {61'd0, seg_addr_v, seg_dataW_v, seg_write_v}, 64'd0);
        tick();
        req_dataR_b = 2'b00;
        #1;
        chk("t6_reos_v2", {62'd0, req_dataR_v}, 64'h2);
        chk("t6_reos_e2", {62'd0, req_dataR_e}, 64'h2);
        tick();
        drive_req(0, 1'b1, 16'h0600, 32'd0, 1'b0, 1'b0);
        #1;
        chk("t6_fin_rv", {62'd0, req_dataR_v}, 64'd0);
        chk("t6_fin_b", {62'd0, req_addr_b}, 64'h3);
        chk("t6_fin_srb", {63'd0, seg_dataR_b}, 64'd1);
        chk("t6_fin_segv", {63'd0, seg_addr_v}, 64'd0);
        chk("t6_fin_err", {63'd0, err}, 64'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_err", {63'd0, err}, 64'd0);
        chk("t6_rst_b", {62'd0, req_addr_b}, 64'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
